// File: rtl/fp_mult_pkg.sv
// Shared defaults and status-flag layout for the multiplier drain buffer.
package fp_mult_pkg;

    localparam int LATENCY_DEF = 3;
    localparam int DEPTH_DEF   = 4;
    localparam int DATA_W      = 32;
    localparam int ENTRY_W     = DATA_W + 3;

    // Field order matches the external {exception, overflow, underflow} bus.
    typedef struct packed {
        logic exception;
        logic overflow;
        logic underflow;
    } fp_flags_t;

endpackage

// File: rtl/fp_mult_drain_if.sv
// Issue/result handshake bundle between multiplier front end, drain buffer and consumer.
interface fp_mult_drain_if;
    import fp_mult_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    logic [DATA_W-1:0] mul_result;
    logic              mul_exception;
    logic              mul_overflow;
    logic              mul_underflow;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    fp_flags_t         out_flags;
    fp_flags_t         sticky_flags;
    logic              clear_sticky;
    logic [15:0]       result_count;

    modport slave (
        input  issue_valid, mul_result, mul_exception, mul_overflow, mul_underflow,
               out_ready, clear_sticky,
        output issue_ready, out_valid, out_data, out_flags, sticky_flags, result_count
    );

    modport master (
        output issue_valid, mul_result, mul_exception, mul_overflow, mul_underflow,
               out_ready, clear_sticky,
        input  issue_ready, out_valid, out_data, out_flags, sticky_flags, result_count
    );

endinterface

// File: rtl/fp_drain_fifo.sv
// Result storage for the drain buffer: DEPTH entries of {flags, data}, FIFO order.
module fp_drain_fifo
    import fp_mult_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = ENTRY_W,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers are PW bits wide, so DEPTH being a power of two gives the wrap for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= wdata;
    end

    assign empty = (count == '0);
    // Head reads as zero when empty so stale storage never leaks onto the bus.
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fp_mult_drain.sv
// Credit-based drain buffer behind a fixed-latency, non-stallable FP multiplier.
// Optional sticky status accumulation is built when FP_DRAIN_STICKY_EN is defined.
module fp_mult_drain
    import fp_mult_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic            clk,
    input  logic            reset,
    fp_mult_drain_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(DEPTH + LATENCY + 1) + 1;

    logic [LATENCY-1:0] inflight;
    logic               accept;
    logic               capture;
    logic               pop;
    logic               empty;
    logic [CW-1:0]      occ;
    logic [SW-1:0]      inflight_cnt;
    logic [SW-1:0]      outstanding;
    logic [ENTRY_W-1:0] head;
    logic [15:0]        result_count_q;

    assign accept  = bus.issue_valid && bus.issue_ready;
    assign capture = inflight[LATENCY-1];
    assign pop     = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) inflight <= '0;
        else       inflight <= (inflight << 1) | LATENCY'(accept);
    end

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < LATENCY; i++)
            inflight_cnt = inflight_cnt + SW'(inflight[i]);
    end

    // Credit counts every result already owed to the buffer; a pop this cycle
    // frees its slot only from the next cycle on.
    assign outstanding     = SW'(occ) + inflight_cnt;
    assign bus.issue_ready = outstanding < SW'(DEPTH);

    fp_drain_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (capture),
        .wdata ({bus.mul_exception, bus.mul_overflow, bus.mul_underflow, bus.mul_result}),
        .pop   (pop),
        .rdata (head),
        .empty (empty),
        .count (occ)
    );

    assign bus.out_valid = !empty;
    assign bus.out_data  = head[DATA_W-1:0];
    assign bus.out_flags = fp_flags_t'(head[ENTRY_W-1:DATA_W]);

    always_ff @(posedge clk) begin
        if (reset)    result_count_q <= '0;
        else if (pop) result_count_q <= result_count_q + 16'd1;
    end
    assign bus.result_count = result_count_q;

`ifdef FP_DRAIN_STICKY_EN
    fp_flags_t sticky_q;
    fp_flags_t cap_flags;

    assign cap_flags = fp_flags_t'({bus.mul_exception, bus.mul_overflow, bus.mul_underflow});

    // A clear coinciding with a capture still keeps the bits that capture sets.
    always_ff @(posedge clk) begin
        if (reset) sticky_q <= '0;
        else       sticky_q <= fp_flags_t'((bus.clear_sticky ? 3'b000 : sticky_q) |
                                           (capture ? cap_flags : 3'b000));
    end
    assign bus.sticky_flags = sticky_q;
`else
    wire unused_clear_sticky = bus.clear_sticky;
    assign bus.sticky_flags = '0;
`endif

endmodule

// File: tb/tb_fp_mult_drain.sv
// Directed + randomized bench for fp_mult_drain with a 3-stage multiplier model and result scoreboard.
module tb_fp_mult_drain;
    import fp_mult_pkg::*;

`ifdef FP_DRAIN_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fp_mult_drain_if bus ();

    fp_mult_drain #(.DEPTH(4), .LATENCY(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int pops     = 0;
    int accepts  = 0;

    logic [31:0] op_res = '0;
    fp_flags_t   op_flg = '0;
    fp_flags_t   acc_or = '0;
    logic        acc_q  = 1'b0;
    logic [34:0] mpipe [3];
    logic [34:0] sb [$];

    // Multiplier model: operands accepted in cycle t present their product in cycle t+3.
    always @(posedge clk) begin
        mpipe[0] <= acc_q ? {op_flg, op_res} : 35'd0;
        mpipe[1] <= mpipe[0];
        mpipe[2] <= mpipe[1];
    end
    assign bus.mul_result    = mpipe[2][31:0];
    assign bus.mul_underflow = mpipe[2][32];
    assign bus.mul_overflow  = mpipe[2][33];
    assign bus.mul_exception = mpipe[2][34];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard: push on accept, pop/compare on each delivered result.
    always @(negedge clk) begin
        logic [34:0] e;
        acc_q <= bus.issue_valid && bus.issue_ready && !reset;
        if (reset) begin
            sb.delete();
            pops    = 0;
            accepts = 0;
            acc_or  = '0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_pop", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("pop_data", bus.out_data, e[31:0]);
                    check("pop_flags", 32'(bus.out_flags), 32'(e[34:32]));
                end
            end
            if (bus.issue_valid && bus.issue_ready) begin
                sb.push_back({op_flg, op_res});
                accepts++;
                acc_or = acc_or | op_flg;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        bus.issue_valid  = 1'b0;
        bus.out_ready    = 1'b0;
        bus.clear_sticky = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.issue_valid  = 1'b0;
        bus.out_ready    = 1'b0;
        bus.clear_sticky = 1'b0;

        // Reset state and single-result latency
        do_reset();
        neg();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_flags", 32'(bus.out_flags), 32'd0);
        check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        check("rst_result_count", 32'(bus.result_count), 32'd0);
        check("rst_sticky", 32'(bus.sticky_flags), 32'd0);
        tick();
        bus.issue_valid = 1'b1; op_res = 32'h40C00000; op_flg = 3'b000;
        neg();
        check("lat_ready_t", 32'(bus.issue_ready), 32'd1);
        tick();
        bus.issue_valid = 1'b0;
        neg();
        check("lat_valid_t1", 32'(bus.out_valid), 32'd0);
        tick(); neg();
        check("lat_valid_t2", 32'(bus.out_valid), 32'd0);
        tick(); neg();
        check("lat_valid_t3", 32'(bus.out_valid), 32'd0);
        tick(); neg();
        check("lat_valid_t4", 32'(bus.out_valid), 32'd1);
        check("lat_data_t4", bus.out_data, 32'h40C00000);
        check("lat_flags_t4", 32'(bus.out_flags), 32'd0);
        tick(); neg();
        check("hold_data", bus.out_data, 32'h40C00000);
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        neg();
        check("lat_count", 32'(bus.result_count), 32'd1);
        check("lat_empty", 32'(bus.out_valid), 32'd0);

        // Credit limit with a stalled consumer, then drain in order
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.issue_valid = 1'b1;
            op_res = 32'h3F800000 + 32'(i);
            op_flg = 3'b000;
            neg();
        end
        check("full_accepts", 32'(accepts), 32'd4);
        check("full_ready", 32'(bus.issue_ready), 32'd0);
        tick();
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b1;
        neg();
        check("pop_cycle_ready", 32'(bus.issue_ready), 32'd0);
        tick();
        bus.out_ready = 1'b0;
        neg();
        check("after_pop_ready", 32'(bus.issue_ready), 32'd1);
        tick();
        bus.out_ready = 1'b1;
        repeat (5) tick();
        bus.out_ready = 1'b0;
        neg();
        check("drain_count", 32'(bus.result_count), 32'd4);
        check("drain_empty", 32'(bus.out_valid), 32'd0);
        check("drain_sb", 32'(sb.size()), 32'd0);

        // Overflow flag, sticky hold and clear
        do_reset();
        tick();
        bus.issue_valid = 1'b1; op_res = 32'h7F800000; op_flg = 3'b010;
        tick();
        bus.issue_valid = 1'b0;
        tick(); tick(); tick();
        neg();
        check("ovf_flags", 32'(bus.out_flags), 32'd2);
        check("ovf_sticky", 32'(bus.sticky_flags), STICKY_ON ? 32'd2 : 32'd0);
        tick(); tick();
        neg();
        check("ovf_sticky_hold", 32'(bus.sticky_flags), STICKY_ON ? 32'd2 : 32'd0);
        tick();
        bus.clear_sticky = 1'b1;
        tick();
        bus.clear_sticky = 1'b0;
        neg();
        check("ovf_sticky_clr", 32'(bus.sticky_flags), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Clear coinciding with an underflow capture
        tick();
        bus.issue_valid = 1'b1; op_res = 32'h00000001; op_flg = 3'b010;
        tick();
        op_res = 32'h00000002; op_flg = 3'b001;
        tick();
        bus.issue_valid = 1'b0;
        tick();
        tick();
        bus.clear_sticky = 1'b1;
        neg();
        check("clr_pre_sticky", 32'(bus.sticky_flags), STICKY_ON ? 32'd2 : 32'd0);
        tick();
        bus.clear_sticky = 1'b0;
        neg();
        check("clr_set_wins", 32'(bus.sticky_flags), STICKY_ON ? 32'd1 : 32'd0);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        bus.out_ready = 1'b0;

        // Reset with one buffered and two in flight
        do_reset();
        tick();
        bus.issue_valid = 1'b1; op_res = 32'h11111111; op_flg = 3'b000;
        tick();
        bus.issue_valid = 1'b0;
        tick();
        bus.issue_valid = 1'b1; op_res = 32'h22222222;
        tick();
        op_res = 32'h33333333;
        tick();
        bus.issue_valid = 1'b0;
        reset = 1'b1;
        neg();
        check("mid_buffered", 32'(bus.out_valid), 32'd1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            neg();
            check("mid_valid", 32'(bus.out_valid), 32'd0);
            check("mid_ready", 32'(bus.issue_ready), 32'd1);
            check("mid_count", 32'(bus.result_count), 32'd0);
            tick();
        end

        // Random traffic against the scoreboard
        do_reset();
        for (int i = 0; i < 80; i++) begin
            tick();
            bus.issue_valid = 1'($urandom_range(0, 1));
            bus.out_ready   = 1'($urandom_range(0, 1));
            op_res = $urandom;
            op_flg = fp_flags_t'($urandom_range(0, 7));
        end
        tick();
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (12) tick();
        bus.out_ready = 1'b0;
        neg();
        check("rnd_sb_empty", 32'(sb.size()), 32'd0);
        check("rnd_out_valid", 32'(bus.out_valid), 32'd0);
        check("rnd_count", 32'(bus.result_count), 32'(pops));
        check("rnd_sticky", 32'(bus.sticky_flags), STICKY_ON ? 32'(acc_or) : 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
